// File: rtl/gelato_ram_arb.sv
// gelato_ram_arb: round-robin arbiter that lets NUM_PORTS core masters share one
// memory port, with one transaction outstanding at a time and a BUSY timeout.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   core_valid        per-port request, held until that port's core_done
//   core_write        per-port write (1) / read (0)
//   core_addr         per-port address, port i at [i*ADDR_W +: ADDR_W]
//   core_wdata        per-port write data, same packing
//   core_done         one-cycle completion pulse per port
//   core_err          timeout flag, valid with core_done
//   core_data         per-port read data, port i at [i*DATA_W +: DATA_W]
//   mem_valid/write/addr/wdata  registered memory-side request
//   mem_done, mem_data          memory completion and read data
//   busy              high while a transaction is in BUSY or RESP
module gelato_ram_arb #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        core_valid,
  input  logic [NUM_PORTS-1:0]        core_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] core_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] core_wdata,
  output logic [NUM_PORTS-1:0]        core_done,
  output logic [NUM_PORTS-1:0]        core_err,
  output logic [NUM_PORTS*DATA_W-1:0] core_data,
  output logic                        mem_valid,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_done,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        busy
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_PORTS - 1);
  // Counter value seen on the final allowed BUSY cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [GW-1:0]               last_grant_q, last_grant_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        mem_valid_d, mem_write_d;
  logic [ADDR_W-1:0]           mem_addr_d;
  logic [DATA_W-1:0]           mem_wdata_d;
  logic [NUM_PORTS-1:0]        core_done_d, core_err_d;
  logic [NUM_PORTS*DATA_W-1:0] core_data_d;
  logic                        busy_d;

  logic          found;
  logic [GW-1:0] pick;

  // Round-robin search starting just after the last granted port.
  always_comb begin : rr_pick
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      idx = 32'(last_grant_q) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && core_valid[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid;
    mem_write_d  = mem_write;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    core_done_d  = '0;
    core_err_d   = '0;
    core_data_d  = core_data;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          mem_valid_d  = 1'b1;
          mem_write_d  = core_write[pick];
          mem_addr_d   = core_addr[32'(pick)*ADDR_W +: ADDR_W];
          mem_wdata_d  = core_wdata[32'(pick)*DATA_W +: DATA_W];
        end
      end
      BUSY: begin
        // mem_done takes priority over a timeout on the same cycle.
        if (mem_done) begin
          state_d              = RESP;
          mem_valid_d          = 1'b0;
          core_done_d[grant_q] = 1'b1;
          if (!mem_write) core_data_d[32'(grant_q)*DATA_W +: DATA_W] = mem_data;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d              = RESP;
          mem_valid_d          = 1'b0;
          core_done_d[grant_q] = 1'b1;
          core_err_d[grant_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // No grant here: gives the finished master a cycle to drop core_valid.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
      mem_valid    <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_done    <= '0;
      core_err     <= '0;
      core_data    <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_valid    <= mem_valid_d;
      mem_write    <= mem_write_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      core_done    <= core_done_d;
      core_err     <= core_err_d;
      core_data    <= core_data_d;
      busy         <= busy_d;
    end
  end

endmodule
